// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : id_ex_stage                                                      |
// | Purpose : ID/EX pipeline register with write-back bypass, load-use stall,  |
// |           branch flush and a saturating bubble counter.                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       busA,
  input  logic [31:0]       busB,
  input  logic [4:0]        Ra,
  input  logic [4:0]        Rb,
  input  logic              UseRb,
  input  logic [4:0]        Rw_id,
  input  logic              RegWr_id,
  input  logic              MemRead_id,
  input  logic [31:0]       Imm_id,
  input  logic [CTRL_W-1:0] Ctrl_id,
  input  logic [31:0]       busW,
  input  logic [4:0]        Rw_wb,
  input  logic              RegWr_wb,
  input  logic              Flush,
  output logic [31:0]       A_ex,
  output logic [31:0]       B_ex,
  output logic [31:0]       Imm_ex,
  output logic [4:0]        Ra_ex,
  output logic [4:0]        Rb_ex,
  output logic [4:0]        Rw_ex,
  output logic              RegWr_ex,
  output logic              MemRead_ex,
  output logic [CTRL_W-1:0] Ctrl_ex,
  output logic              Valid_ex,
  output logic              Stall,
  output logic [CNT_W-1:0]  BubbleCnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] w_opA;
  logic [31:0] w_opB;
  logic        w_hazard;

  // The register file writes on the same edge we capture, so its read ports
  // still show the stale value; steer the write-back data in instead.
  assign w_opA = (RegWr_wb && (Rw_wb == Ra) && (Ra != 5'd0)) ? busW : busA;
  assign w_opB = (RegWr_wb && (Rw_wb == Rb) && (Rb != 5'd0)) ? busW : busB;

  assign w_hazard = Valid_ex && MemRead_ex && (Rw_ex != 5'd0) &&
                    ((Rw_ex == Ra) || (UseRb && (Rw_ex == Rb)));

  // Flush outranks the hazard; reset masks the stall while EX is not yet cleared.
  assign Stall = w_hazard && !Flush && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      A_ex       <= '0;
      B_ex       <= '0;
      Imm_ex     <= '0;
      Ra_ex      <= '0;
      Rb_ex      <= '0;
      Rw_ex      <= '0;
      RegWr_ex   <= 1'b0;
      MemRead_ex <= 1'b0;
      Ctrl_ex    <= '0;
      Valid_ex   <= 1'b0;
      BubbleCnt  <= '0;
    end else if (Flush || Stall) begin
      A_ex       <= '0;
      B_ex       <= '0;
      Imm_ex     <= '0;
      Ra_ex      <= '0;
      Rb_ex      <= '0;
      Rw_ex      <= '0;
      RegWr_ex   <= 1'b0;
      MemRead_ex <= 1'b0;
      Ctrl_ex    <= '0;
      Valid_ex   <= 1'b0;
      // Only hazard bubbles are counted; flush bubbles are not.
      if (Stall && (BubbleCnt != c_CNT_MAX)) begin
        BubbleCnt <= BubbleCnt + 1'b1;
      end
    end else begin
      A_ex       <= w_opA;
      B_ex       <= w_opB;
      Imm_ex     <= Imm_id;
      Ra_ex      <= Ra;
      Rb_ex      <= Rb;
      Rw_ex      <= Rw_id;
      RegWr_ex   <= RegWr_id;
      MemRead_ex <= MemRead_id;
      Ctrl_ex    <= Ctrl_id;
      Valid_ex   <= 1'b1;
    end
  end

endmodule
`default_nettype wire
